// File: rtl/smpc_pkg.sv
// Shared types and byte constants for the SMPC peripheral collector.
// The state enum is used by the top; header bytes by the port sequencer.
package smpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PHDR,
    ST_IDB,
    ST_FETCH,
    ST_PAGE,
    ST_DONE
  } smpc_state_e;

  localparam logic [7:0] HDR_EMPTY   = 8'hF0;
  localparam logic [7:0] HDR_PRESENT = 8'hF1;
  localparam logic [7:0] ID_NONE     = 8'hFF;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned max_len);
    clamp_len = (32'(len) > max_len) ? 4'(max_len) : len;
  endfunction

endpackage

// File: rtl/smpc_port_seq.sv
// Per-port header/length decode for the collector: selects the latched
// descriptor of the current port and forms its header and ID/length bytes.
module smpc_port_seq
  import smpc_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_LEN   = 15,
  parameter int PORT_W    = 1
) (
  input  logic [NUM_PORTS-1:0]   port_en,
  input  logic [8*NUM_PORTS-1:0] pad_id,
  input  logic [4*NUM_PORTS-1:0] pad_len,
  input  logic [PORT_W-1:0]      port,
  output logic                   has_dev,
  output logic [7:0]             hdr_byte,
  output logic [7:0]             idb_byte,
  output logic [3:0]             len_c
);

  logic [NUM_PORTS-1:0] dev_ok;
  logic [3:0]           len_arr [NUM_PORTS];
  logic [3:0]           id_hi_arr [NUM_PORTS];
  logic [3:0]           sel_id_hi;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign dev_ok[gi]    = port_en[gi] && (pad_id[8*gi +: 8] != ID_NONE);
    assign len_arr[gi]   = clamp_len(pad_len[4*gi +: 4], MAX_LEN);
    assign id_hi_arr[gi] = pad_id[8*gi+4 +: 4];
  end

  always_comb begin
    has_dev   = 1'b0;
    len_c     = 4'd0;
    sel_id_hi = 4'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port == PORT_W'(i)) begin
        has_dev   = dev_ok[i];
        len_c     = len_arr[i];
        sel_id_hi = id_hi_arr[i];
      end
    end
  end

  assign hdr_byte = has_dev ? HDR_PRESENT : HDR_EMPTY;
  assign idb_byte = {sel_id_hi, len_c};

endmodule

// File: rtl/smpc_periph_collector.sv
// Collects per-port pad headers and payloads into a paged output buffer,
// pausing at each full page until the host continues or aborts.
module smpc_periph_collector
  import smpc_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int OREG_DEPTH = 32,
  parameter  int MAX_LEN    = 15,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int ADDR_W     = $clog2(OREG_DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   CE,
  input  logic                   START,
  input  logic                   CONT,
  input  logic                   BRK,
  input  logic [NUM_PORTS-1:0]   PORT_EN,
  input  logic [8*NUM_PORTS-1:0] PAD_ID,
  input  logic [4*NUM_PORTS-1:0] PAD_LEN,
  output logic                   PAD_REQ,
  output logic [PORT_W-1:0]      PAD_PORT,
  output logic [3:0]             PAD_IDX,
  input  logic                   PAD_ACK,
  input  logic [7:0]             PAD_DATA,
  output logic                   OREG_WE,
  output logic [ADDR_W-1:0]      OREG_ADDR,
  output logic [7:0]             OREG_WD,
  output logic                   PAGE_RDY,
  output logic                   MORE,
  output logic                   BUSY
);

  smpc_state_e state_reg, state_next, rs_state_reg, rs_state_next, adv_state;
  logic [PORT_W-1:0] port_reg, port_next, rs_port_reg, rs_port_next, adv_port;
  logic [3:0]        idx_reg, idx_next, rs_idx_reg, rs_idx_next, adv_idx;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [NUM_PORTS-1:0]   en_reg;
  logic [8*NUM_PORTS-1:0] id_reg;
  logic [4*NUM_PORTS-1:0] len_reg;
  logic page_rdy_reg, more_reg;
  logic wr_en, latch_en, page_set, more_set, step_port;
  logic [7:0] wr_data;
  logic has_dev;
  logic [7:0] hdr_byte, idb_byte;
  logic [3:0] len_c;

  smpc_port_seq #(
    .NUM_PORTS(NUM_PORTS),
    .MAX_LEN  (MAX_LEN),
    .PORT_W   (PORT_W)
  ) u_port_seq (
    .port_en (en_reg),
    .pad_id  (id_reg),
    .pad_len (len_reg),
    .port    (port_reg),
    .has_dev (has_dev),
    .hdr_byte(hdr_byte),
    .idb_byte(idb_byte),
    .len_c   (len_c)
  );

  always_comb begin
    state_next    = state_reg;
    port_next     = port_reg;
    idx_next      = idx_reg;
    addr_next     = addr_reg;
    rs_state_next = rs_state_reg;
    rs_port_next  = rs_port_reg;
    rs_idx_next   = rs_idx_reg;
    adv_state     = state_reg;
    adv_port      = port_reg;
    adv_idx       = idx_reg;
    wr_en         = 1'b0;
    wr_data       = 8'h00;
    latch_en      = 1'b0;
    page_set      = 1'b0;
    more_set      = 1'b0;
    step_port     = 1'b0;
    if (CE) begin
      if (BRK && state_reg != ST_IDLE) begin
        state_next = ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: if (START) begin
            latch_en   = 1'b1;
            state_next = ST_PHDR;
            port_next  = '0;
            idx_next   = '0;
            addr_next  = '0;
          end
          ST_PHDR: begin
            wr_en   = 1'b1;
            wr_data = hdr_byte;
            if (has_dev) adv_state = ST_IDB;
            else         step_port = 1'b1;
          end
          ST_IDB: begin
            wr_en   = 1'b1;
            wr_data = idb_byte;
            adv_idx = '0;
            if (len_c == 4'd0) step_port = 1'b1;
            else               adv_state = ST_FETCH;
          end
          ST_FETCH: if (PAD_ACK) begin
            wr_en   = 1'b1;
            wr_data = PAD_DATA;
            if (idx_reg == len_c - 4'd1) step_port = 1'b1;
            else                         adv_idx   = idx_reg + 4'd1;
          end
          ST_PAGE: if (CONT) begin
            state_next = rs_state_reg;
            port_next  = rs_port_reg;
            idx_next   = rs_idx_reg;
            addr_next  = '0;
          end
          ST_DONE: state_next = ST_IDLE;
          default: state_next = ST_IDLE;
        endcase

        if (step_port) begin
          adv_idx = '0;
          if (port_reg == PORT_W'(NUM_PORTS - 1)) begin
            adv_state = ST_DONE;
          end else begin
            adv_state = ST_PHDR;
            adv_port  = port_reg + PORT_W'(1);
          end
        end

        // A write into the last slot pauses only if the walk is not finished.
        if (wr_en) begin
          addr_next = addr_reg + ADDR_W'(1);
          if (addr_reg == ADDR_W'(OREG_DEPTH - 1) && adv_state != ST_DONE) begin
            state_next    = ST_PAGE;
            rs_state_next = adv_state;
            rs_port_next  = adv_port;
            rs_idx_next   = adv_idx;
            page_set      = 1'b1;
            more_set      = 1'b1;
          end else begin
            state_next = adv_state;
            port_next  = adv_port;
            idx_next   = adv_idx;
            page_set   = (adv_state == ST_DONE);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      port_reg     <= '0;
      idx_reg      <= '0;
      addr_reg     <= '0;
      rs_state_reg <= ST_IDLE;
      rs_port_reg  <= '0;
      rs_idx_reg   <= '0;
      en_reg       <= '0;
      id_reg       <= '0;
      len_reg      <= '0;
      page_rdy_reg <= 1'b0;
      more_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      port_reg     <= port_next;
      idx_reg      <= idx_next;
      addr_reg     <= addr_next;
      rs_state_reg <= rs_state_next;
      rs_port_reg  <= rs_port_next;
      rs_idx_reg   <= rs_idx_next;
      page_rdy_reg <= page_set;
      more_reg     <= more_set;
      if (latch_en) begin
        en_reg  <= PORT_EN;
        id_reg  <= PAD_ID;
        len_reg <= PAD_LEN;
      end
    end
  end

  assign PAD_REQ   = (state_reg == ST_FETCH);
  assign PAD_PORT  = port_reg;
  assign PAD_IDX   = idx_reg;
  assign OREG_WE   = wr_en;
  assign OREG_ADDR = addr_reg;
  assign OREG_WD   = wr_data;
  assign PAGE_RDY  = page_rdy_reg;
  assign MORE      = more_reg;
  assign BUSY      = (state_reg != ST_IDLE);

endmodule
